// File: rtl/riscv_if_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package riscv_if_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  // FETCH: reading from the cache; HOLD: one fetched word parked while decode stalls;
  // DRAIN: waiting out an in-flight read whose result is on the wrong path.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } if_state_t;

  // Word-align a byte address.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/riscv_if.sv
// Instruction-fetch stage: owns the PC, reads the I-cache, loads the IF/ID register.
// Cache handshake: a read is issued while ic_ren is high and completes on the cycle
// ic_stall is low; ic_addr is held stable for as long as ic_stall stays high.
module riscv_if
  import riscv_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ic_ren,
  output logic [29:0] ic_addr,
  input  logic [31:0] ic_rdata,
  input  logic        ic_stall,
  output logic [31:0] inst_ppl,
  output logic [31:0] pc_ppl,
  output logic        if_busy,
  output if_state_t   state
);

  if_state_t   state_n;
  logic [31:0] pc_r, pc_n;
  logic [31:0] pend_pc, pend_n;
  logic [31:0] buf_inst, buf_n;
  logic [31:0] buf_pc, buf_pc_n;
  logic [31:0] inst_n, pcp_n;
  logic [31:0] pc_inc;

  // The cache must see no request while reset is asserted, even mid-read.
  assign ic_ren  = rst_n && (state != HOLD);
  assign ic_addr = pc_r[31:2];
  assign if_busy = (state == DRAIN) || (ic_ren && ic_stall);
  assign pc_inc  = pc_r + 32'd4;

  // Next-state, next-PC and IF/ID selection.
  always_comb begin
    state_n  = state;
    pc_n     = pc_r;
    pend_n   = pend_pc;
    buf_n    = buf_inst;
    buf_pc_n = buf_pc;
    inst_n   = inst_ppl;
    pcp_n    = pc_ppl;
    unique case (state)
      FETCH: begin
        if (redirect && ic_stall) begin
          // Read cannot be aborted: remember the target and wait for it to finish.
          pend_n  = align_pc(redirect_pc);
          inst_n  = NOP_INST;
          pcp_n   = pc_r;
          state_n = DRAIN;
        end else if (redirect) begin
          pc_n   = align_pc(redirect_pc);
          inst_n = NOP_INST;
          pcp_n  = pc_r;
        end else if (ic_stall) begin
          if (!stall) begin
            inst_n = NOP_INST;
            pcp_n  = pc_r;
          end
        end else if (!stall) begin
          inst_n = ic_rdata;
          pcp_n  = pc_r;
          pc_n   = pc_inc;
        end else begin
          buf_n    = ic_rdata;
          buf_pc_n = pc_r;
          pc_n     = pc_inc;
          state_n  = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_n    = align_pc(redirect_pc);
          inst_n  = NOP_INST;
          pcp_n   = pc_r;
          state_n = FETCH;
        end else if (!stall) begin
          inst_n  = buf_inst;
          pcp_n   = buf_pc;
          state_n = FETCH;
        end
      end
      DRAIN: begin
        // Youngest redirect target wins, including one arriving on the completion cycle.
        if (redirect) pend_n = align_pc(redirect_pc);
        if (!ic_stall) begin
          pc_n    = redirect ? align_pc(redirect_pc) : pend_pc;
          state_n = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  // All fetch state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      pc_r     <= align_pc(RESET_PC);
      pend_pc  <= '0;
      buf_inst <= '0;
      buf_pc   <= '0;
      inst_ppl <= NOP_INST;
      pc_ppl   <= '0;
    end else begin
      state    <= state_n;
      pc_r     <= pc_n;
      pend_pc  <= pend_n;
      buf_inst <= buf_n;
      buf_pc   <= buf_pc_n;
      inst_ppl <= inst_n;
      pc_ppl   <= pcp_n;
    end
  end

endmodule

// File: tb/tb_riscv_if.sv
// Directed bench for the instruction-fetch stage.
module tb_riscv_if;
  import riscv_if_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ic_ren;
  logic [29:0] ic_addr;
  logic [31:0] ic_rdata;
  logic        ic_stall = 1'b0;
  logic [31:0] inst_ppl;
  logic [31:0] pc_ppl;
  logic        if_busy;
  if_state_t   state;

  int tests = 0;
  int fails = 0;

  // Clock / reset
  always #5 clk = ~clk;

  riscv_if dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .ic_ren(ic_ren), .ic_addr(ic_addr),
    .ic_rdata(ic_rdata), .ic_stall(ic_stall), .inst_ppl(inst_ppl),
    .pc_ppl(pc_ppl), .if_busy(if_busy), .state(state)
  );

  // Cache content model: word 0 holds addi x1,x0,5; every other word tags its own byte address.
  assign ic_rdata = (ic_addr == 30'd0) ? 32'h0050_0093 : (32'hA000_0000 | {ic_addr, 2'b00});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_ren", 32'(ic_ren), 32'd0);
    chk("rst_inst", inst_ppl, NOP);
    chk("rst_pcppl", pc_ppl, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_addr", 32'(ic_addr), 32'd0);
    chk("rst_ren1", 32'(ic_ren), 32'd1);

    // T1: first fetch
    step();
    chk("t1_inst", inst_ppl, 32'h0050_0093);
    chk("t1_pc", pc_ppl, 32'd0);
    chk("t1_addr", 32'(ic_addr), 32'd1);
    step();
    chk("t1b_inst", inst_ppl, 32'hA000_0004);
    chk("t1b_addr", 32'(ic_addr), 32'd2);

    // T2: three cache-stall bubbles at pc 8
    ic_stall = 1'b1;
    #1;
    chk("t2_busy", 32'(if_busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_inst", inst_ppl, NOP);
      chk("t2_pc", pc_ppl, 32'h8);
      chk("t2_addr", 32'(ic_addr), 32'd2);
    end
    ic_stall = 1'b0;
    step();
    chk("t2_real", inst_ppl, 32'hA000_0008);
    chk("t2_realpc", pc_ppl, 32'h8);
    chk("t2_next", 32'(ic_addr), 32'd3);

    // T3: decode stall when the word at 0xC arrives
    stall = 1'b1;
    step();
    chk("t3_state", 32'(state), 32'(HOLD));
    chk("t3_ren", 32'(ic_ren), 32'd0);
    chk("t3_held", inst_ppl, 32'hA000_0008);
    step();
    chk("t3_held2", inst_ppl, 32'hA000_0008);
    stall = 1'b0;
    step();
    chk("t3_inst", inst_ppl, 32'hA000_000C);
    chk("t3_pc", pc_ppl, 32'hC);
    chk("t3_addr", 32'(ic_addr), 32'd4);
    step();
    chk("t3_next", inst_ppl, 32'hA000_0010);
    chk("t3_nextpc", pc_ppl, 32'h10);

    // T4: redirect to 0x40 with the cache ready; data at 0x14 is dropped
    redirect = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    chk("t4_nop", inst_ppl, NOP);
    chk("t4_addr", 32'(ic_addr), 32'h10);
    step();
    chk("t4_inst", inst_ppl, 32'hA000_0040);
    chk("t4_pc", pc_ppl, 32'h40);

    // T5: redirect during a cache stall, second redirect while draining
    ic_stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h80;
    step();
    chk("t5_state", 32'(state), 32'(DRAIN));
    chk("t5_nop", inst_ppl, NOP);
    chk("t5_addr", 32'(ic_addr), 32'h11);
    redirect_pc = 32'h90;
    step();
    redirect = 1'b0;
    chk("t5_addr2", 32'(ic_addr), 32'h11);
    chk("t5_busy", 32'(if_busy), 32'd1);
    step();
    chk("t5_addr3", 32'(ic_addr), 32'h11);
    ic_stall = 1'b0;
    step();
    chk("t5_addr4", 32'(ic_addr), 32'h24);
    chk("t5_stillnop", inst_ppl, NOP);
    step();
    chk("t5_inst", inst_ppl, 32'hA000_0090);
    chk("t5_pc", pc_ppl, 32'h90);

    // T6: redirect while holding a buffered word under stall
    stall = 1'b1;
    step();
    chk("t6_state", 32'(state), 32'(HOLD));
    redirect = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    stall = 1'b0;
    chk("t6_nop", inst_ppl, NOP);
    chk("t6_addr", 32'(ic_addr), 32'h40);
    step();
    chk("t6_inst", inst_ppl, 32'hA000_0100);
    chk("t6_pc", pc_ppl, 32'h100);

    // PC wrap and low-bit masking of the redirect target
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect = 1'b0;
    chk("wrap_addr", 32'(ic_addr), 32'h3FFF_FFFF);
    step();
    chk("wrap_inst", inst_ppl, 32'hFFFF_FFFC);
    chk("wrap_pc", pc_ppl, 32'hFFFF_FFFC);
    chk("wrap_addr0", 32'(ic_addr), 32'd0);
    step();
    chk("wrap_inst0", inst_ppl, 32'h0050_0093);

    // Asynchronous reset in the middle of a stalled read
    ic_stall = 1'b1;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_ren", 32'(ic_ren), 32'd0);
    chk("mrst_inst", inst_ppl, NOP);
    chk("mrst_addr", 32'(ic_addr), 32'd0);
    ic_stall = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("mrst_first", inst_ppl, 32'h0050_0093);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
